// File: rtl/prescaler_multi_pkg.sv
// ============================================================================
//  Module      : prescaler_multi_pkg
//  Description : Shared defaults and helpers for the multi-channel prescaler.
//                Holds the reset-divisor helper and the channel-select width
//                formula used by the top level and its channel instances.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prescaler_multi_pkg;

   localparam int C_DEFAULT_NBITS = 13;
   localparam int C_DEFAULT_NCH   = 2;

   // Width of the channel-select field; a single channel still gets one bit.
   function automatic int chw_f(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   // Reset divisor is the all-ones value, giving a tick every 2**NBITS cycles.
   function automatic int reset_div_f(input int nbits);
      return (1 << nbits) - 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/prescaler_multi_chan.sv
// ============================================================================
//  Module      : prescaler_multi_chan
//  Description : One prescaler channel: counter, active/shadow divisor,
//                pending flag, one-cycle tick and 50% square output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prescaler_multi_chan
   import prescaler_multi_pkg::*;
#(
   parameter int NBITS = C_DEFAULT_NBITS
)(
   input  logic             clk_fast,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             wr,
   input  logic [NBITS-1:0] wdata,
   output logic             tick,
   output logic             sq,
   output logic             pend
);

   localparam logic [NBITS-1:0] C_RST_DIV = NBITS'(reset_div_f(NBITS));

   logic [NBITS-1:0] r_count;
   logic [NBITS-1:0] r_active;
   logic [NBITS-1:0] r_shadow;
   logic             r_pend;
   logic             r_tick;
   logic             r_sq;

   logic             w_off;
   logic             w_wrap;

   assign w_off  = (r_active == '0);
   assign w_wrap = (r_count == r_active);

   // Channel state update: reset, then sync, then off/freeze, then counting.
   always_ff @(posedge clk_fast) begin
      if (!rst) begin
         r_count  <= '0;
         r_active <= C_RST_DIV;
         r_shadow <= C_RST_DIV;
         r_pend   <= 1'b0;
         r_tick   <= 1'b0;
         r_sq     <= 1'b0;
      end else if (sync) begin
         // Realign: a write in the same cycle goes straight to active.
         r_count <= '0;
         r_tick  <= 1'b0;
         r_sq    <= 1'b0;
         r_pend  <= 1'b0;
         if (wr) begin
            r_active <= wdata;
            r_shadow <= wdata;
         end else if (r_pend) begin
            r_active <= r_shadow;
         end
      end else begin
         // Writes always land in the shadow; a write beats a same-edge clear.
         if (wr) begin
            r_shadow <= wdata;
            r_pend   <= 1'b1;
         end
         if (w_off) begin
            // Off channel picks up a pending divisor even while frozen.
            r_count <= '0;
            r_tick  <= 1'b0;
            if (r_pend) begin
               r_active <= r_shadow;
               if (!wr) begin
                  r_pend <= 1'b0;
               end
            end
         end else if (!en) begin
            r_tick <= 1'b0;
         end else if (w_wrap) begin
            r_count <= '0;
            r_tick  <= 1'b1;
            r_sq    <= ~r_sq;
            if (r_pend) begin
               r_active <= r_shadow;
               if (!wr) begin
                  r_pend <= 1'b0;
               end
            end
         end else begin
            r_count <= r_count + 1'b1;
            r_tick  <= 1'b0;
         end
      end
   end

   assign tick = r_tick;
   assign sq   = r_sq;
   assign pend = r_pend;

endmodule

`default_nettype wire

// File: rtl/prescaler_multi.sv
// ============================================================================
//  Module      : prescaler_multi
//  Description : Multi-channel programmable clock-enable generator. Decodes
//                the divisor write port into per-channel strobes and
//                instantiates one independent channel per output bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prescaler_multi
   import prescaler_multi_pkg::*;
#(
   parameter  int NBITS = C_DEFAULT_NBITS,
   parameter  int NCH   = C_DEFAULT_NCH,
   localparam int CHW   = chw_f(NCH)
)(
   input  logic             clk_fast,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             cfg_we,
   input  logic [CHW-1:0]   cfg_ch,
   input  logic [NBITS-1:0] cfg_div,
   output logic [NCH-1:0]   tick,
   output logic [NCH-1:0]   sq,
   output logic [NCH-1:0]   pend
);

   logic [NCH-1:0] w_wr;

   // One-hot write decode; channel numbers at or above NCH match nothing.
   always_comb begin
      w_wr = '0;
      for (int i = 0; i < NCH; i++) begin
         w_wr[i] = cfg_we && (cfg_ch == CHW'(i));
      end
   end

   generate
      for (genvar g = 0; g < NCH; g++) begin : g_chan
         prescaler_multi_chan #(
            .NBITS (NBITS)
         ) u_chan (
            .clk_fast (clk_fast),
            .rst      (rst),
            .en       (en),
            .sync     (sync),
            .wr       (w_wr[g]),
            .wdata    (cfg_div),
            .tick     (tick[g]),
            .sq       (sq[g]),
            .pend     (pend[g])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_prescaler_multi.sv
// ============================================================================
//  Module      : tb_prescaler_multi
//  Description : Directed self-checking bench for prescaler_multi with
//                NBITS=4, NCH=3.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prescaler_multi;

   localparam int NBITS = 4;
   localparam int NCH   = 3;

   logic             clk_fast = 1'b0;
   logic             rst      = 1'b0;
   logic             en       = 1'b0;
   logic             sync     = 1'b0;
   logic             cfg_we   = 1'b0;
   logic [1:0]       cfg_ch   = '0;
   logic [NBITS-1:0] cfg_div  = '0;
   logic [NCH-1:0]   tick;
   logic [NCH-1:0]   sq;
   logic [NCH-1:0]   pend;

   int checks   = 0;
   int failures = 0;

   prescaler_multi #(
      .NBITS (NBITS),
      .NCH   (NCH)
   ) dut (
      .clk_fast (clk_fast),
      .rst      (rst),
      .en       (en),
      .sync     (sync),
      .cfg_we   (cfg_we),
      .cfg_ch   (cfg_ch),
      .cfg_div  (cfg_div),
      .tick     (tick),
      .sq       (sq),
      .pend     (pend)
   );

   always #5 clk_fast = ~clk_fast;

   // Advance one edge; outputs are stable 1 time unit after it.
   task automatic step();
      @(posedge clk_fast);
      #1;
   endtask

   // Steps until tick[ch] is seen high; returns limit+1 if it never is.
   task automatic wait_tick(input int ch, input int limit, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!tick[ch] && n <= limit);
   endtask

   task automatic do_reset();
      rst = 1'b0; en = 1'b0; sync = 1'b0; cfg_we = 1'b0;
      step();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      int n;
      do_reset();
      checks++;
      if (tick !== 3'b000 || sq !== 3'b000 || pend !== 3'b000) begin
         failures++;
         $display("FAIL reset_state: tick=%b sq=%b pend=%b required 000/000/000", tick, sq, pend);
      end
      en = 1'b1;
      wait_tick(0, 40, n);
      checks++;
      if (n !== 16 || tick !== 3'b111 || sq !== 3'b111) begin
         failures++;
         $display("FAIL reset_first_tick: n=%0d tick=%b sq=%b required 16/111/111", n, tick, sq);
      end
      wait_tick(0, 40, n);
      checks++;
      if (n !== 16 || sq !== 3'b000 || pend !== 3'b000) begin
         failures++;
         $display("FAIL reset_period: n=%0d sq=%b pend=%b required 16/000/000", n, sq, pend);
      end
   endtask

   task automatic test_reload();
      int n;
      // Continues from test_reset: all counts are 0 here.
      repeat (5) step();
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 4'd9;
      step();
      cfg_div = 4'd3;
      step();
      cfg_we = 1'b0;
      checks++;
      if (pend !== 3'b010) begin
         failures++;
         $display("FAIL reload_pend: pend=%b required 010", pend);
      end
      wait_tick(1, 40, n);
      checks++;
      if (n !== 9 || tick !== 3'b111 || pend !== 3'b000) begin
         failures++;
         $display("FAIL reload_old_wrap: n=%0d tick=%b pend=%b required 9/111/000", n, tick, pend);
      end
      wait_tick(1, 40, n);
      checks++;
      if (n !== 4 || tick !== 3'b010) begin
         failures++;
         $display("FAIL reload_new_period: n=%0d tick=%b required 4/010", n, tick);
      end
      wait_tick(1, 40, n);
      checks++;
      if (n !== 4) begin
         failures++;
         $display("FAIL reload_new_period2: n=%0d required 4", n);
      end
   endtask

   task automatic test_off_on();
      int n;
      int bad;
      do_reset();
      en = 1'b1;
      cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 4'd0;
      step();
      cfg_we = 1'b0;
      wait_tick(2, 40, n);
      checks++;
      if (n !== 15 || pend[2] !== 1'b0 || sq[2] !== 1'b1) begin
         failures++;
         $display("FAIL off_last_wrap: n=%0d pend2=%b sq2=%b required 15/0/1", n, pend[2], sq[2]);
      end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (tick[2] !== 1'b0 || sq[2] !== 1'b1) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL off_hold: bad_cycles=%0d required 0", bad);
      end
      cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 4'd2;
      step();
      cfg_we = 1'b0;
      checks++;
      if (pend[2] !== 1'b1) begin
         failures++;
         $display("FAIL on_pend_set: pend2=%b required 1", pend[2]);
      end
      step();
      checks++;
      if (pend[2] !== 1'b0) begin
         failures++;
         $display("FAIL on_applied: pend2=%b required 0", pend[2]);
      end
      wait_tick(2, 40, n);
      checks++;
      if (n !== 3 || sq[2] !== 1'b0) begin
         failures++;
         $display("FAIL on_first_tick: n=%0d sq2=%b required 3/0", n, sq[2]);
      end
      wait_tick(2, 40, n);
      checks++;
      if (n !== 3) begin
         failures++;
         $display("FAIL on_period: n=%0d required 3", n);
      end
   endtask

   task automatic test_freeze();
      int n;
      int bad;
      do_reset();
      en = 1'b1;
      wait_tick(0, 40, n);
      repeat (4) step();
      en = 1'b0;
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 4'd7;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         cfg_we = 1'b0;
         if (tick !== 3'b000) bad++;
      end
      checks++;
      if (bad !== 0 || pend !== 3'b010) begin
         failures++;
         $display("FAIL freeze_hold: bad_cycles=%0d pend=%b required 0/010", bad, pend);
      end
      en = 1'b1;
      wait_tick(0, 40, n);
      checks++;
      if (n + 9 !== 21) begin
         failures++;
         $display("FAIL freeze_stretch: period=%0d required 21", n + 9);
      end
   endtask

   task automatic test_align();
      int first [NCH];
      do_reset();
      en = 1'b1;
      cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 4'd9;
      step();
      cfg_we = 1'b0;
      repeat (19) step();
      sync = 1'b1;
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 4'd5;
      step();
      sync = 1'b0; cfg_we = 1'b0;
      checks++;
      if (tick !== 3'b000 || sq !== 3'b000 || pend !== 3'b000) begin
         failures++;
         $display("FAIL align_state: tick=%b sq=%b pend=%b required 000/000/000", tick, sq, pend);
      end
      for (int c = 0; c < NCH; c++) first[c] = 0;
      for (int i = 1; i <= 17; i++) begin
         step();
         for (int c = 0; c < NCH; c++) begin
            if (tick[c] && first[c] == 0) first[c] = i;
         end
      end
      checks++;
      if (first[0] !== 6 || first[1] !== 16 || first[2] !== 10) begin
         failures++;
         $display("FAIL align_ticks: ch0=%0d ch1=%0d ch2=%0d required 6/16/10", first[0], first[1], first[2]);
      end
   endtask

   task automatic test_edges();
      int n;
      do_reset();
      en = 1'b1;
      cfg_we = 1'b1; cfg_ch = 2'd3; cfg_div = 4'd1;
      step();
      cfg_we = 1'b0;
      checks++;
      if (pend !== 3'b000) begin
         failures++;
         $display("FAIL bad_ch_pend: pend=%b required 000", pend);
      end
      wait_tick(0, 40, n);
      checks++;
      if (n !== 15 || tick !== 3'b111) begin
         failures++;
         $display("FAIL bad_ch_period: n=%0d tick=%b required 15/111", n, tick);
      end
      repeat (15) step();
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 4'd2;
      step();
      cfg_we = 1'b0;
      checks++;
      if (tick[0] !== 1'b1 || pend[0] !== 1'b1) begin
         failures++;
         $display("FAIL wrap_write: tick0=%b pend0=%b required 1/1", tick[0], pend[0]);
      end
      wait_tick(0, 40, n);
      checks++;
      if (n !== 16 || pend[0] !== 1'b0) begin
         failures++;
         $display("FAIL wrap_write_old: n=%0d pend0=%b required 16/0", n, pend[0]);
      end
      wait_tick(0, 40, n);
      checks++;
      if (n !== 3) begin
         failures++;
         $display("FAIL wrap_write_new: n=%0d required 3", n);
      end
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 4'd4;
      step();
      cfg_we = 1'b0;
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      checks++;
      if (tick !== 3'b000 || sq !== 3'b000 || pend !== 3'b000) begin
         failures++;
         $display("FAIL midrst_state: tick=%b sq=%b pend=%b required 000/000/000", tick, sq, pend);
      end
      wait_tick(0, 40, n);
      checks++;
      if (n !== 16 || tick !== 3'b111) begin
         failures++;
         $display("FAIL midrst_period: n=%0d tick=%b required 16/111", n, tick);
      end
   endtask

   initial begin
      test_reset();
      test_reload();
      test_off_on();
      test_freeze();
      test_align();
      test_edges();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
